// File: rtl/mealy_prog_if.sv
// rtl/mealy_prog_if.sv - control, config and status bundle of the programmable Mealy machine
interface mealy_prog_if #(
    parameter int STATE_W = 3,
    parameter int IN_W    = 2,
    parameter int OUT_W   = 1,
    parameter int CNT_W   = 8
);
    logic [IN_W-1:0]          sw_in;
    logic                     ctrl_in;
    logic                     load;
    logic [STATE_W-1:0]       state_in;
    logic                     cfg_we;
    logic [STATE_W+IN_W-1:0]  cfg_addr;
    logic [STATE_W+OUT_W-1:0] cfg_wdata;
    logic [STATE_W-1:0]       state;
    logic [OUT_W-1:0]         out;
    logic [CNT_W-1:0]         step_cnt;
    logic                     err;

    modport master (
        output sw_in, ctrl_in, load, state_in, cfg_we, cfg_addr, cfg_wdata,
        input  state, out, step_cnt, err
    );

    modport slave (
        input  sw_in, ctrl_in, load, state_in, cfg_we, cfg_addr, cfg_wdata,
        output state, out, step_cnt, err
    );
endinterface

// File: rtl/mealy_prog.sv
// rtl/mealy_prog.sv - runtime-programmable Mealy machine with step counter and sticky error
module mealy_prog #(
    parameter int STATE_W    = 3,
    parameter int NUM_STATES = 8,
    parameter int IN_W       = 2,
    parameter int OUT_W      = 1,
    parameter int CNT_W      = 8
) (
    input  logic         clk,
    input  logic         reset_n,
    mealy_prog_if.slave  bus
);
    localparam int                 IDX_W  = STATE_W + IN_W;
    localparam int                 ENT_W  = STATE_W + OUT_W;
    localparam int                 DEPTH  = 2 ** IDX_W;
    localparam logic [STATE_W:0]   NS     = NUM_STATES[STATE_W:0];
    localparam logic [CNT_W-1:0]   CNT_MAX = '1;

    // Rows for illegal states are never written, so they stay constant and trim away.
    logic [ENT_W-1:0]   r_tbl [DEPTH];
    logic [STATE_W-1:0] r_state;
    logic [OUT_W-1:0]   r_out;
    logic [CNT_W-1:0]   r_cnt;
    logic               r_err;

    logic [IDX_W-1:0]   w_rd_idx;
    logic [ENT_W-1:0]   w_entry;
    logic [STATE_W-1:0] w_next;
    logic [OUT_W-1:0]   w_next_out;
    logic [STATE_W-1:0] w_wr_state;
    logic               w_wr_ok;
    logic               w_next_ok;
    logic               w_load_ok;

    assign w_rd_idx   = {r_state, bus.sw_in};
    assign w_entry    = r_tbl[w_rd_idx];
    assign w_next     = w_entry[ENT_W-1:OUT_W];
    assign w_next_out = w_entry[OUT_W-1:0];
    assign w_wr_state = bus.cfg_addr[IDX_W-1:IN_W];
    assign w_wr_ok    = bus.cfg_we && ({1'b0, w_wr_state} < NS);
    assign w_next_ok  = {1'b0, w_next} < NS;
    assign w_load_ok  = {1'b0, bus.state_in} < NS;

    // A write to the entry being stepped through lands after the read, so the step sees the old value.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_tbl   <= '{default: '0};
            r_state <= '0;
            r_out   <= '0;
            r_cnt   <= '0;
            r_err   <= 1'b0;
        end else begin
            if (w_wr_ok) begin
                r_tbl[bus.cfg_addr] <= bus.cfg_wdata;
            end
            if (bus.load) begin
                r_out <= '0;
                r_cnt <= '0;
                if (w_load_ok) begin
                    r_state <= bus.state_in;
                    r_err   <= 1'b0;
                end else begin
                    r_state <= '0;
                    r_err   <= 1'b1;
                end
            end else if (bus.ctrl_in && !r_err) begin
                if (w_next_ok) begin
                    r_state <= w_next;
                    r_out   <= w_next_out;
                    if (r_cnt != CNT_MAX) begin
                        r_cnt <= r_cnt + 1'b1;
                    end
                end else begin
                    r_err <= 1'b1;
                end
            end
        end
    end

    assign bus.state    = r_state;
    assign bus.out      = r_out;
    assign bus.step_cnt = r_cnt;
    assign bus.err      = r_err;
endmodule

// File: tb/tb_mealy_prog.sv
// tb/tb_mealy_prog.sv - bench for mealy_prog: two instances (8 states/8-bit count, 6 states/2-bit count)
module tb_mealy_prog;
    logic clk = 1'b0;
    logic reset_n = 1'b0;
    always #5 clk = ~clk;

    logic [1:0] d_sw = '0;
    logic       d_ctrl = 1'b0;
    logic       d_load = 1'b0;
    logic [2:0] d_state_in = '0;
    logic       d_we = 1'b0;
    logic [4:0] d_addr = '0;
    logic [3:0] d_wdata = '0;

    mealy_prog_if #(.STATE_W(3), .IN_W(2), .OUT_W(1), .CNT_W(8)) if_a ();
    mealy_prog_if #(.STATE_W(3), .IN_W(2), .OUT_W(1), .CNT_W(2)) if_b ();

    assign if_a.sw_in = d_sw;      assign if_b.sw_in = d_sw;
    assign if_a.ctrl_in = d_ctrl;  assign if_b.ctrl_in = d_ctrl;
    assign if_a.load = d_load;     assign if_b.load = d_load;
    assign if_a.state_in = d_state_in; assign if_b.state_in = d_state_in;
    assign if_a.cfg_we = d_we;     assign if_b.cfg_we = d_we;
    assign if_a.cfg_addr = d_addr; assign if_b.cfg_addr = d_addr;
    assign if_a.cfg_wdata = d_wdata; assign if_b.cfg_wdata = d_wdata;

    mealy_prog #(.STATE_W(3), .NUM_STATES(8), .IN_W(2), .OUT_W(1), .CNT_W(8)) u_a (
        .clk(clk), .reset_n(reset_n), .bus(if_a.slave));
    mealy_prog #(.STATE_W(3), .NUM_STATES(6), .IN_W(2), .OUT_W(1), .CNT_W(2)) u_b (
        .clk(clk), .reset_n(reset_n), .bus(if_b.slave));

    int n_chk = 0;
    int n_pass = 0;

    // Reference: table as (next, out) integer arrays, one per instance.
    int m_next [2][32];
    int m_outv [2][32];
    int m_state [2];
    int m_out [2];
    int m_cnt [2];
    int m_err [2];

    function automatic int ns_of(input int k);
        return (k == 0) ? 8 : 6;
    endfunction

    function automatic int cmax_of(input int k);
        return (k == 0) ? 255 : 3;
    endfunction

    task automatic model_clear();
        for (int k = 0; k < 2; k++) begin
            for (int e = 0; e < 32; e++) begin
                m_next[k][e] = 0;
                m_outv[k][e] = 0;
            end
            m_state[k] = 0; m_out[k] = 0; m_cnt[k] = 0; m_err[k] = 0;
        end
    endtask

    task automatic model_step(input int k);
        int rd, en, eo;
        rd = m_state[k] * 4 + int'(d_sw);
        en = m_next[k][rd];
        eo = m_outv[k][rd];
        if (d_we && (int'(d_addr) / 4) < ns_of(k)) begin
            m_next[k][d_addr] = int'(d_wdata) / 2;
            m_outv[k][d_addr] = int'(d_wdata) % 2;
        end
        if (d_load) begin
            m_out[k] = 0;
            m_cnt[k] = 0;
            if (int'(d_state_in) < ns_of(k)) begin
                m_state[k] = int'(d_state_in);
                m_err[k] = 0;
            end else begin
                m_state[k] = 0;
                m_err[k] = 1;
            end
        end else if (d_ctrl && m_err[k] == 0) begin
            if (en < ns_of(k)) begin
                m_state[k] = en;
                m_out[k] = eo;
                if (m_cnt[k] < cmax_of(k)) m_cnt[k] = m_cnt[k] + 1;
            end else begin
                m_err[k] = 1;
            end
        end
    endtask

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_chk++;
        if (act !== exp) $display("FAIL %s: got %0d expected %0d at %0t", nm, act, exp, $time);
        else n_pass++;
    endtask

    initial begin
        model_clear();
        forever begin
            @(posedge clk or negedge reset_n);
            if (!reset_n) model_clear();
            else begin
                model_step(0);
                model_step(1);
            end
        end
    end

    initial begin
        forever begin
            @(negedge clk);
            chk("a_state", 32'(if_a.state), m_state[0]);
            chk("a_out", 32'(if_a.out), m_out[0]);
            chk("a_cnt", 32'(if_a.step_cnt), m_cnt[0]);
            chk("a_err", 32'(if_a.err), m_err[0]);
            chk("b_state", 32'(if_b.state), m_state[1]);
            chk("b_out", 32'(if_b.out), m_out[1]);
            chk("b_cnt", 32'(if_b.step_cnt), m_cnt[1]);
            chk("b_err", 32'(if_b.err), m_err[1]);
        end
    end

    task automatic cyc(input logic [1:0] sw, input logic ctrl, input logic ld, input logic [2:0] sin,
                       input logic we, input logic [4:0] addr, input logic [3:0] wd);
        d_sw = sw; d_ctrl = ctrl; d_load = ld; d_state_in = sin;
        d_we = we; d_addr = addr; d_wdata = wd;
        @(posedge clk);
        @(negedge clk);
    endtask

    task automatic step(input logic [1:0] sw);
        cyc(sw, 1'b1, 1'b0, 3'd0, 1'b0, 5'd0, 4'd0);
    endtask

    task automatic do_load(input logic [2:0] s);
        cyc(2'd0, 1'b0, 1'b1, s, 1'b0, 5'd0, 4'd0);
    endtask

    task automatic wr(input logic [4:0] a, input int nx, input int o);
        cyc(2'd0, 1'b0, 1'b0, 3'd0, 1'b1, a, 4'((nx << 1) | o));
    endtask

    // Two-state table from the test plan as {next, out} per input symbol.
    int prog_next [8] = '{0, 0, 1, 1, 0, 1, 1, 1};
    int prog_out  [8] = '{1, 0, 1, 1, 0, 1, 1, 0};

    initial begin
        for (int i = 0; i < 3; i++) cyc(2'(i), 1'b0, 1'b0, 3'd0, 1'b0, 5'd0, 4'd0);
        @(negedge clk);
        reset_n = 1'b1;
        for (int i = 0; i < 4; i++) cyc(2'(i), 1'b0, 1'b0, 3'd0, 1'b0, 5'd0, 4'd0);
        chk("idle_state", 32'(if_a.state), 0);
        chk("idle_cnt", 32'(if_a.step_cnt), 0);

        for (int e = 0; e < 8; e++) wr(5'(e), prog_next[e], prog_out[e]);
        do_load(3'd0);
        step(2'd2);
        chk("lit_s1_state", 32'(if_a.state), 1);
        chk("lit_s1_out", 32'(if_a.out), 1);
        step(2'd3);
        chk("lit_s2_out", 32'(if_a.out), 0);
        step(2'd0);
        step(2'd1);
        chk("lit_seq_state", 32'(if_a.state), 0);
        chk("lit_seq_cnt", 32'(if_a.step_cnt), 4);
        chk("lit_sat_b_cnt", 32'(if_b.step_cnt), 3);

        cyc(2'd2, 1'b1, 1'b0, 3'd0, 1'b1, 5'd2, 4'd0);
        chk("lit_coll_state", 32'(if_a.state), 1);
        chk("lit_coll_out", 32'(if_a.out), 1);
        do_load(3'd0);
        step(2'd2);
        chk("lit_new_state", 32'(if_a.state), 0);
        chk("lit_new_out", 32'(if_a.out), 0);

        wr(5'd4, 7, 1);
        do_load(3'd1);
        step(2'd0);
        chk("lit_ill_err", 32'(if_b.err), 1);
        chk("lit_ill_state", 32'(if_b.state), 1);
        chk("lit_ill_a_state", 32'(if_a.state), 7);
        step(2'd1);
        chk("lit_ill_hold", 32'(if_b.state), 1);
        do_load(3'd2);
        chk("lit_clr_err", 32'(if_b.err), 0);
        chk("lit_clr_state", 32'(if_b.state), 2);

        cyc(2'd0, 1'b1, 1'b1, 3'd3, 1'b0, 5'd0, 4'd0);
        chk("lit_ldpri_state", 32'(if_a.state), 3);
        chk("lit_ldpri_cnt", 32'(if_a.step_cnt), 0);
        do_load(3'd7);
        chk("lit_illd_state", 32'(if_b.state), 0);
        chk("lit_illd_err", 32'(if_b.err), 1);

        do_load(3'd0);
        for (int i = 0; i < 5; i++) step(2'd0);
        chk("lit_sat_cnt", 32'(if_b.step_cnt), 3);
        chk("lit_nosat_cnt", 32'(if_a.step_cnt), 5);
        step(2'd0);
        step(2'd0);
        d_ctrl = 1'b1;
        #2 reset_n = 1'b0;
        #1;
        chk("lit_arst_cnt", 32'(if_b.step_cnt), 0);
        chk("lit_arst_out", 32'(if_a.out), 0);
        chk("lit_arst_state", 32'(if_a.state), 0);
        @(negedge clk);
        reset_n = 1'b1;
        step(2'd2);
        chk("lit_tbl_cleared", 32'(if_a.out), 0);

        for (int n = 0; n < 3000; n++) begin
            cyc(2'($urandom_range(0, 3)),
                1'($urandom_range(0, 3) != 0),
                1'($urandom_range(0, 15) == 0),
                3'($urandom_range(0, 7)),
                1'($urandom_range(0, 2) == 0),
                5'($urandom_range(0, 31)),
                4'($urandom_range(0, 15)));
        end

        @(posedge clk);
        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end
endmodule

// File: doc/mealy_prog.md
Name: mealy_prog

Overview:
Runtime-programmable Mealy machine. It generalises the fixed 2-state, 2-bit-input, hard-coded-table machine to NUM_STATES states, IN_W-bit input and OUT_W-bit output. The transition/output table is written through a config port, and the block adds a step counter and illegal-state detection. It sits behind the switch/control front end and is stepped by ctrl_in, one transition per enabled clock.

Parameters:
STATE_W, 3, state encoding width
NUM_STATES, 8, number of legal states (2..2**STATE_W); codes >= NUM_STATES are illegal
IN_W, 2, input symbol width; the table has NUM_STATES*2**IN_W entries
OUT_W, 1, output symbol width
CNT_W, 8, step counter width (saturating)

Ports:
clk  input  1  system clock, all state updates on rising edge
reset_n  input  1  asynchronous active-low reset
sw_in  input  IN_W  current input symbol
ctrl_in  input  1  step enable: take one transition this cycle
load  input  1  synchronous restart to state_in
state_in  input  STATE_W  state loaded by load
cfg_we  input  1  table write strobe
cfg_addr  input  STATE_W+IN_W  entry index {state, input symbol}
cfg_wdata  input  STATE_W+OUT_W  entry value {next_state, out_value}
state  output  STATE_W  current state (registered)
out  output  OUT_W  output of the last transition (registered)
step_cnt  output  CNT_W  transitions taken since reset/load, saturating
err  output  1  sticky illegal-state / illegal-load flag

Behaviour:
- Reset (reset_n low, asynchronous): state=0, out=0, step_cnt=0, err=0, all table entries={0,0}. Outputs hold these values until the first enabled clock after reset_n rises.
- Table: registered array of NUM_STATES*2**IN_W entries. It is read combinationally at index {state, sw_in}.
  - cfg_we=1 writes cfg_wdata to entry cfg_addr at the clock edge.
  - Entries with cfg_addr state field >= NUM_STATES are ignored; no write, no err.
- Priority per cycle: load > step. A table write is independent and happens in the same cycle as either.
- Load (load=1):
  - state<=state_in, out<=0, step_cnt<=0, err<=0.
  - If state_in >= NUM_STATES: state<=0 and err<=1 instead.
  - ctrl_in is ignored in a load cycle.
- Step (load=0, ctrl_in=1, err=0):
  - Read entry E at {state, sw_in}.
  - If E.next < NUM_STATES: state<=E.next, out<=E.out, step_cnt<=step_cnt+1, saturating at 2**CNT_W-1.
  - If E.next >= NUM_STATES: state and out hold, step_cnt holds, err<=1.
- Steps are ignored while err=1 (state/out/step_cnt hold). Only load or reset clears err.
- ctrl_in=0 and load=0: all outputs hold. sw_in changes have no effect on outputs; out is registered, so there is no combinational Mealy path to the port.
- Latency: a transition is visible on state/out one clock after the ctrl_in cycle.
- Write/step collision: if cfg_we targets the same entry the step reads, the step uses the OLD entry value. The new value applies from the next cycle.
- Reset mid-operation: asynchronous reset overrides everything, including the table contents. The table must be reprogrammed after reset.

Test Plan:
- Reset then idle: reset_n low 3 cycles, toggle sw_in, ctrl_in=0 -> state=0, out=0, step_cnt=0, err=0 throughout.
- Program 2-state table with entries (next,out):
  - s0: in0->(0,1), in1->(0,0), in2->(1,1), in3->(1,1)
  - s1: in0->(0,0), in1->(1,1), in2->(1,1), in3->(1,0)
  - Then load state_in=0 and step sw_in=2,3,0,1 -> (state,out) = (1,1), (1,0), (0,0), (0,0); step_cnt=4.
- Collision: in s0, step with sw_in=2 while writing entry {0,2}=(0,0) in the same cycle -> state=1, out=1 (old value). Then load 0 and step sw_in=2 -> state=0, out=0.
- Illegal next: NUM_STATES=6, entry {1,0}=(7,1), from s1 step sw_in=0 -> err=1, state=1 holds. Further steps are ignored. load state_in=2 -> err=0, state=2.
- Load priority and illegal load: load=1, ctrl_in=1, state_in=3 -> state=3, step_cnt=0, no transition. load state_in=7 with NUM_STATES=6 -> state=0, err=1.
- Saturation: CNT_W=2, 5 consecutive legal steps -> step_cnt=3 and holds. Assert reset_n mid-sequence -> all outputs 0 asynchronously, before the next clk edge.
